// File: rtl/compmux_scan_pkg.sv
// Shared definitions for the comparator-mux scan sequencer: sizes, FSM state codes
// and the channel-search helpers.
package compmux_scan_pkg;

  localparam int NCH   = 16;
  localparam int SEL_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_DWELL  = 2'd2;
  localparam state_t ST_REPORT = 2'd3;

  // Returns {found, idx}: lowest enabled channel strictly above cur.
  function automatic logic [SEL_W:0] next_enabled(input logic [NCH-1:0] mask,
                                                  input logic [SEL_W-1:0] cur);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r = {1'b1, SEL_W'(i)};
      end
    end
    return r;
  endfunction

  // Returns {found, idx}: lowest enabled channel overall.
  function automatic logic [SEL_W:0] lowest_enabled(input logic [NCH-1:0] mask);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r = {1'b1, SEL_W'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/compmux_scan_ctrl_if.sv
// Result stream from the scan sequencer to the readout logic (valid/ready).
interface compmux_scan_ctrl_if #(
  parameter int DWELL_W = 12
);
  import compmux_scan_pkg::*;

  logic               res_valid;
  logic               res_ready;
  logic [SEL_W-1:0]   res_chan;
  logic [DWELL_W-1:0] res_count;

  modport master (output res_valid, output res_chan, output res_count, input res_ready);
  modport slave  (input res_valid, input res_chan, input res_count, output res_ready);
endinterface

// File: rtl/compmux_scan_cnt.sv
// Shared settle/dwell down-counter plus the comparator-high accumulator.
module compmux_scan_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         acc_clr,
  input  logic         acc_en,
  input  logic         sample,
  output logic         last,
  output logic [W-1:0] acc_sum
);
  logic [W-1:0] cnt_reg;
  logic [W-1:0] acc_reg;

  // Loads are always >= 1, so a count of one marks the final cycle of a window.
  assign last    = (cnt_reg == W'(1));
  assign acc_sum = acc_reg + W'(sample);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      acc_reg <= '0;
    end else begin
      if (load) begin
        cnt_reg <= load_val;
      end else if (dec) begin
        cnt_reg <= cnt_reg - W'(1);
      end
      if (acc_clr) begin
        acc_reg <= '0;
      end else if (acc_en) begin
        acc_reg <= acc_sum;
      end
    end
  end
endmodule

// File: rtl/compmux_scan_ctrl.sv
// Comparator-mux scan sequencer: settle, dwell-count and report each enabled channel.
// Build option COMPMUX_SCAN_SYNC_EN adds a 2-flop synchronizer on comp_in.
module compmux_scan_ctrl
  import compmux_scan_pkg::*;
#(
  parameter int DWELL_W  = 12,
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [NCH-1:0]      chan_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [DWELL_W-1:0]  dwell_cycles,
  input  logic                comp_in,
  output logic [SEL_W-1:0]    mux_sel,
  output logic                busy,
  output logic                done,
  compmux_scan_ctrl_if.master res
);
  logic sample;

`ifdef COMPMUX_SCAN_SYNC_EN
  // Two extra settle cycles flush the synchronizer after every select change.
  localparam int SYNC_EXTRA = 2;
  logic [1:0] sync_reg;
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[0], comp_in};
  end
  assign sample = sync_reg[1];
`else
  localparam int SYNC_EXTRA = 0;
  assign sample = comp_in;
`endif

  state_t               state_reg, state_next;
  logic [NCH-1:0]       mask_reg;
  logic                 cont_reg;
  logic [DWELL_W-1:0]   settle_len_reg, dwell_len_reg;
  logic [SEL_W-1:0]     mux_sel_reg, sel_next;
  logic                 res_valid_reg, valid_next;
  logic [SEL_W-1:0]     res_chan_reg, chan_next;
  logic [DWELL_W-1:0]   res_count_reg, count_next;
  logic                 done_reg, done_next;
  logic                 latch;
  logic                 go;
  logic [SEL_W-1:0]     go_sel;
  logic [DWELL_W-1:0]   go_settle, go_dwell;
  logic                 cnt_load, cnt_dec, acc_clr, acc_en, cnt_last;
  logic [DWELL_W-1:0]   cnt_load_val, acc_sum;
  logic [DWELL_W-1:0]   settle_in, dwell_in;
  logic [SEL_W:0]       first_hit, next_hit, wrap_hit;

  assign settle_in = DWELL_W'(settle_cycles) + DWELL_W'(SYNC_EXTRA);
  assign dwell_in  = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
  assign first_hit = lowest_enabled(chan_mask);
  assign next_hit  = next_enabled(mask_reg, mux_sel_reg);
  assign wrap_hit  = lowest_enabled(mask_reg);

  always_comb begin
    state_next   = state_reg;
    sel_next     = mux_sel_reg;
    valid_next   = res_valid_reg;
    chan_next    = res_chan_reg;
    count_next   = res_count_reg;
    done_next    = 1'b0;
    latch        = 1'b0;
    go           = 1'b0;
    go_sel       = mux_sel_reg;
    go_settle    = settle_len_reg;
    go_dwell     = dwell_len_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          latch = 1'b1;
          if (first_hit[SEL_W]) begin
            go        = 1'b1;
            go_sel    = first_hit[SEL_W-1:0];
            go_settle = settle_in;
            go_dwell  = dwell_in;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_last) begin
          state_next   = ST_DWELL;
          cnt_load     = 1'b1;
          cnt_load_val = dwell_len_reg;
          acc_clr      = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DWELL: begin
        acc_en = 1'b1;
        if (cnt_last) begin
          state_next = ST_REPORT;
          valid_next = 1'b1;
          chan_next  = mux_sel_reg;
          count_next = acc_sum;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_REPORT: begin
        if (res.res_ready) begin
          valid_next = 1'b0;
          if (next_hit[SEL_W]) begin
            go     = 1'b1;
            go_sel = next_hit[SEL_W-1:0];
          end else if (cont_reg) begin
            go     = 1'b1;
            go_sel = wrap_hit[SEL_W-1:0];
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A zero settle window skips SETTLE and opens the dwell window immediately.
    if (go) begin
      sel_next = go_sel;
      cnt_load = 1'b1;
      if (go_settle == '0) begin
        state_next   = ST_DWELL;
        cnt_load_val = go_dwell;
        acc_clr      = 1'b1;
      end else begin
        state_next   = ST_SETTLE;
        cnt_load_val = go_settle;
      end
    end

    if (stop && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      valid_next = 1'b0;
      done_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      mask_reg       <= '0;
      cont_reg       <= 1'b0;
      settle_len_reg <= '0;
      dwell_len_reg  <= '0;
      mux_sel_reg    <= '0;
      res_valid_reg  <= 1'b0;
      res_chan_reg   <= '0;
      res_count_reg  <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mux_sel_reg   <= sel_next;
      res_valid_reg <= valid_next;
      res_chan_reg  <= chan_next;
      res_count_reg <= count_next;
      done_reg      <= done_next;
      if (latch) begin
        mask_reg       <= chan_mask;
        cont_reg       <= continuous;
        settle_len_reg <= settle_in;
        dwell_len_reg  <= dwell_in;
      end
    end
  end

  compmux_scan_cnt #(.W(DWELL_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .sample   (sample),
    .last     (cnt_last),
    .acc_sum  (acc_sum)
  );

  assign mux_sel       = mux_sel_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = done_reg;
  assign res.res_valid = res_valid_reg;
  assign res.res_chan  = res_chan_reg;
  assign res.res_count = res_count_reg;
endmodule
